// File: rtl/crc_serial_checker.sv
// Receive-side serial CRC checker: recomputes the LFSR over the data bits, then
// compares the trailing CRC bits (LSB first) and reports a registered per-frame result.
module crc_serial_checker #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'b01000100,
    parameter logic [WIDTH-1:0] SEED  = 8'h00,
    parameter int               LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_en,
    input  logic             crc_en,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             trunc_err,
    output logic             proto_err,
    output logic [LEN_W-1:0] frame_len
);

    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic               mis_q, mis_d;
    logic [KW-1:0]      k_q, k_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               crc_ok_q, crc_ok_d;
    logic               crc_err_q, crc_err_d;
    logic               trunc_q, trunc_d;
    logic               proto_q, proto_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;

    logic               bit_mis;
    logic               finish;
    logic               abort_trunc;
    logic               abort_proto;
    logic [LEN_W-1:0]   len_inc;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur, input logic b);
        logic [WIDTH-1:0] nxt;
        logic             fb;
        fb = b ^ cur[0];
        nxt[WIDTH-1] = fb;
        for (int i = 0; i < WIDTH-1; i++) begin
            nxt[i] = cur[i+1] ^ (TAPS[i] & fb);
        end
        return nxt;
    endfunction

    // The LFSR stays frozen during CHECK, so bit k of the CRC is compared to lfsr_q[k].
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        mis_d       = mis_q;
        k_d         = k_q;
        len_d       = len_q;
        done_d      = 1'b0;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = crc_err_q;
        trunc_d     = trunc_q;
        proto_d     = proto_q;
        frame_len_d = frame_len_q;
        finish      = 1'b0;
        abort_trunc = 1'b0;
        abort_proto = 1'b0;
        bit_mis     = ser_in ^ lfsr_q[k_q];
        len_inc     = (&len_q) ? len_q : len_q + LEN_W'(1);

        if (data_en && crc_en) begin
            abort_proto = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_en) begin
                        lfsr_d  = lfsr_next(lfsr_q, ser_in);
                        len_d   = LEN_W'(1);
                        state_d = DATA;
                    end else if (crc_en) begin
                        mis_d   = bit_mis;
                        k_d     = KW'(1);
                        state_d = CHECK;
                    end
                end
                DATA: begin
                    if (data_en) begin
                        lfsr_d = lfsr_next(lfsr_q, ser_in);
                        len_d  = len_inc;
                    end else if (crc_en) begin
                        mis_d   = mis_q | bit_mis;
                        k_d     = KW'(1);
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (data_en) begin
                        abort_trunc = 1'b1;
                    end else if (crc_en) begin
                        if (k_q == KW'(WIDTH-1)) begin
                            finish = 1'b1;
                        end else begin
                            mis_d = mis_q | bit_mis;
                            k_d   = k_q + KW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (finish || abort_trunc || abort_proto) begin
            done_d      = 1'b1;
            crc_ok_d    = finish && !(mis_q | bit_mis);
            crc_err_d   = !(finish && !(mis_q | bit_mis));
            trunc_d     = abort_trunc;
            proto_d     = abort_proto;
            frame_len_d = len_q;
            lfsr_d      = SEED;
            mis_d       = 1'b0;
            k_d         = '0;
            len_d       = '0;
            state_d     = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            mis_q       <= 1'b0;
            k_q         <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            trunc_q     <= 1'b0;
            proto_q     <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            mis_q       <= mis_d;
            k_q         <= k_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            trunc_q     <= trunc_d;
            proto_q     <= proto_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign trunc_err = trunc_q;
    assign proto_err = proto_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_crc_serial_checker.sv
// Self-checking bench for crc_serial_checker: per-feature tasks drive frames and push
// expected results; negedge monitors pop and compare whenever a done pulse appears.
module tb_crc_serial_checker;

    localparam logic [7:0] TAPS_TB = 8'b01000100;

    typedef struct packed {
        logic        ok;
        logic        err;
        logic        trunc;
        logic        proto;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_en;
    logic        crc_en;
    logic        ser_in;

    logic        busy, done, crc_ok, crc_err, trunc_err, proto_err;
    logic [15:0] frame_len;
    logic        busy_b, done_b, crc_ok_b, crc_err_b, trunc_err_b, proto_err_b;
    logic [3:0]  frame_len_b;

    int          errors = 0;
    int          checks = 0;
    bit          mon2_en = 1'b0;
    exp_t        q1[$];
    exp_t        q2[$];

    always #5 clk = ~clk;

    crc_serial_checker dut (
        .clk(clk), .rst(rst), .data_en(data_en), .crc_en(crc_en), .ser_in(ser_in),
        .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
        .trunc_err(trunc_err), .proto_err(proto_err), .frame_len(frame_len)
    );

    // Second instance: non-zero seed and a narrow length counter to reach saturation quickly.
    crc_serial_checker #(.WIDTH(8), .TAPS(8'b01000100), .SEED(8'hA5), .LEN_W(4)) dut_b (
        .clk(clk), .rst(rst), .data_en(data_en), .crc_en(crc_en), .ser_in(ser_in),
        .busy(busy_b), .done(done_b), .crc_ok(crc_ok_b), .crc_err(crc_err_b),
        .trunc_err(trunc_err_b), .proto_err(proto_err_b), .frame_len(frame_len_b)
    );

    function automatic exp_t mk(input logic ok, input logic err, input logic tr,
                                input logic pr, input logic [15:0] len);
        return {ok, err, tr, pr, len};
    endfunction

    function automatic logic [7:0] crc_model(input logic [7:0] seed, input logic [31:0] data,
                                             input int n);
        logic [7:0] r;
        logic       fb;
        r = seed;
        for (int i = 0; i < n; i++) begin
            fb = data[i] ^ r[0];
            r  = {fb, r[7:1]} ^ ({8{fb}} & {1'b0, TAPS_TB[6:0]});
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && done === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 required no pending frame");
            end else begin
                e = q1.pop_front();
                if ({crc_ok, crc_err, trunc_err, proto_err, frame_len} !== e) begin
                    errors++;
                    $display("[TB] FAIL frame_result: got ok=%b err=%b tr=%b pr=%b len=%0d required ok=%b err=%b tr=%b pr=%b len=%0d",
                             crc_ok, crc_err, trunc_err, proto_err, frame_len,
                             e.ok, e.err, e.trunc, e.proto, e.len);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_at_done: got %b required 0", busy);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && mon2_en && done_b === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done_b: got done=1 required no pending frame");
            end else begin
                e = q2.pop_front();
                if ({crc_ok_b, crc_err_b, trunc_err_b, proto_err_b, frame_len_b} !==
                    {e.ok, e.err, e.trunc, e.proto, e.len[3:0]}) begin
                    errors++;
                    $display("[TB] FAIL frame_result_b: got ok=%b err=%b tr=%b pr=%b len=%0d required ok=%b err=%b tr=%b pr=%b len=%0d",
                             crc_ok_b, crc_err_b, trunc_err_b, proto_err_b, frame_len_b,
                             e.ok, e.err, e.trunc, e.proto, e.len[3:0]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish required finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic de, input logic ce, input logic b);
        @(negedge clk);
        data_en = de;
        crc_en  = ce;
        ser_in  = b;
    endtask

    task automatic check_busy_high(input string tag);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_%s: got %b required 1", tag, busy);
        end
    endtask

    task automatic send_frame(input logic [31:0] data, input int n, input logic [7:0] crc,
                              input int gap, input bit chk_busy,
                              input exp_t e1, input bit use2, input exp_t e2);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, data[i]);
            if (chk_busy && i > 0) check_busy_high("data");
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0);
                if (chk_busy) check_busy_high("gap");
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                q1.push_back(e1);
                if (use2) q2.push_back(e2);
            end
            drive(1'b0, 1'b1, crc[k]);
            if (chk_busy) check_busy_high("crc");
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    if (chk_busy) check_busy_high("crc_gap");
                end
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        drive(1'b0, 1'b0, 1'b0);
        while ((q1.size() != 0 || (mon2_en && q2.size() != 0)) && t < 20) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (q1.size() != 0 || (mon2_en && q2.size() != 0)) begin
            errors++;
            $display("[TB] FAIL done_timeout: got %0d/%0d pending required 0", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, crc_ok, crc_err, trunc_err, proto_err, frame_len} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h required 0",
                     {busy, done, crc_ok, crc_err, trunc_err, proto_err, frame_len});
        end
        checks++;
        if ({busy_b, done_b, crc_ok_b, crc_err_b, trunc_err_b, proto_err_b, frame_len_b} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_state_b: got %h required 0",
                     {busy_b, done_b, crc_ok_b, crc_err_b, trunc_err_b, proto_err_b, frame_len_b});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_bit();
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drain();
    endtask

    task automatic test_back_to_back();
        send_frame(32'h1, 2, 8'h62, 0, 1'b0, mk(1, 0, 0, 0, 2), 1'b0, '0);
        send_frame(32'h1, 2, 8'h62 ^ 8'h08, 0, 1'b0, mk(0, 1, 0, 0, 2), 1'b0, '0);
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drain();
    endtask

    task automatic test_gaps();
        send_frame(32'h0, 4, 8'h00, 3, 1'b1, mk(1, 0, 0, 0, 4), 1'b0, '0);
        drain();
    endtask

    task automatic test_truncation();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        q1.push_back(mk(0, 1, 1, 0, 1));
        drive(1'b1, 1'b0, 1'b1);
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drain();
    endtask

    task automatic test_protocol();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        q1.push_back(mk(0, 1, 0, 1, 3));
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL proto_idle: got busy=%b required 0", busy);
        end
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        q1.push_back(mk(0, 1, 0, 1, 1));
        drive(1'b1, 1'b1, 1'b0);
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drain();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, i[0]);
        @(negedge clk);
        data_en = 1'b0;
        rst     = 1'b0;
        #1;
        checks++;
        if ({busy, done, crc_ok, crc_err, trunc_err, proto_err, frame_len} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got %h required 0",
                     {busy, done, crc_ok, crc_err, trunc_err, proto_err, frame_len});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        send_frame(32'h1, 1, 8'hC4, 0, 1'b0, mk(1, 0, 0, 0, 1), 1'b0, '0);
        drain();
    endtask

    task automatic test_seed_empty();
        logic [7:0] s = 8'hA5;
        mon2_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            send_frame(32'h0, 0, s, 0, 1'b0, mk(0, 1, 0, 0, 0), 1'b1, mk(1, 0, 0, 0, 0));
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [7:0] c2 = crc_model(8'hA5, 32'h0, 20);
        send_frame(32'h0, 20, c2, 0, 1'b0, mk(c2 == 8'h00, c2 != 8'h00, 0, 0, 20),
                   1'b1, mk(1, 0, 0, 0, 16'd15));
        drain();
        mon2_en = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            logic [31:0] d    = $urandom;
            int          n    = $urandom_range(1, 16);
            int          flip = $urandom_range(0, 1);
            int          pos  = $urandom_range(0, 7);
            int          gap  = $urandom_range(0, 2);
            logic [7:0]  c    = crc_model(8'h00, d, n);
            if (flip != 0) c = c ^ (8'h01 << pos);
            send_frame(d, n, c, gap, 1'b0,
                       mk(flip == 0, flip != 0, 0, 0, 16'(n)), 1'b0, '0);
        end
        drain();
    endtask

    initial begin
        rst     = 1'b0;
        data_en = 1'b0;
        crc_en  = 1'b0;
        ser_in  = 1'b0;
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_gaps();
        test_truncation();
        test_protocol();
        test_reset_midframe();
        test_seed_empty();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_serial_checker.md
# crc_serial_checker

Receive-side counterpart of the serial LFSR CRC generator. It consumes a bit-serial frame, recomputes the CRC over the data bits with the same polynomial and bit order the transmitter uses, then compares the WIDTH transmitted CRC bits that follow. At the end of each frame it reports pass/fail, truncation or protocol errors, and the frame length. It sits on the receive path directly behind the serial deserializer/sampler.

## Interface
- WIDTH, 8, CRC/LFSR width in bits (≥2)
- TAPS, 8'b01000100, feedback tap mask; bit i set means stage i takes `lfsr[i+1] ^ fb`; bit WIDTH-1 ignored
- SEED, 8'h00, LFSR value at reset and at the start of every frame
- LEN_W, 16, width of the data-bit length counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- data_en  in  1  ser_in carries a data bit this cycle
- crc_en  in  1  ser_in carries a CRC bit this cycle
- ser_in  in  1  serial bit
- busy  out  1  frame in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse, frame result valid
- crc_ok  out  1  last frame passed; held until next done
- crc_err  out  1  last frame failed (mismatch, truncation or protocol); held
- trunc_err  out  1  last frame aborted by data_en before all CRC bits arrived; held
- proto_err  out  1  last frame aborted by data_en and crc_en both high; held
- frame_len  out  LEN_W  data bits in last frame, saturating at all-ones; held

## Operation
- LFSR update per data bit: `fb = ser_in ^ lfsr[0]`; `lfsr[WIDTH-1] <= fb`; for i < WIDTH-1, `lfsr[i] <= lfsr[i+1] ^ (TAPS[i] & fb)`.
- CRC bits arrive LSB first: the k-th CRC bit (k = 0..WIDTH-1) is compared against the frozen `lfsr[k]`. Any mismatch sets the sticky `mis` flag.
- States:
  - IDLE
    - data_en: absorb the bit, len = 1, go to DATA.
    - crc_en: empty frame; compare bit 0 against SEED[0], k = 1, go to CHECK.
  - DATA
    - data_en: absorb the bit, len += 1 (saturating).
    - crc_en: compare bit 0, k = 1, go to CHECK.
    - Neither asserted: hold. Idle gaps are legal.
  - CHECK
    - crc_en: compare bit k, k += 1. When the bit with k = WIDTH-1 is consumed, finish the frame.
    - Neither asserted: hold.
    - data_en: abort with trunc_err = 1. The data bit is dropped.
- data_en and crc_en high together, in any state: abort with proto_err = 1. The bit is dropped.
- Finish/abort, in the same edge:
  - Register the result: crc_ok = !mis_final && !abort; crc_err = !crc_ok.
  - frame_len = len.
  - Reload lfsr = SEED; clear mis, k and len; go to IDLE.
- Reset (asserted at any time, including mid-frame):
  - lfsr = SEED; state IDLE; k = 0; len = 0; mis = 0.
  - Outputs: busy 0, done 0, crc_ok 0, crc_err 0, trunc_err 0, proto_err 0, frame_len 0.
  - No done pulse is generated for the interrupted frame.
- On abort, trunc_err and proto_err are mutually exclusive. Both are cleared on a successful done.

## Timing
- Inputs are sampled on the rising edge; all outputs are registered.
- done is high in exactly the cycle after the edge that sampled the final CRC bit (or the aborting input). crc_ok, crc_err, trunc_err, proto_err and frame_len update on that same edge.
- A new frame's first data_en is accepted in the cycle done is high. The checker is back-to-back capable with zero dead cycles.
- busy rises the cycle after the first accepted bit and falls together with the done assertion.
- Throughput: one bit per cycle; arbitrary gaps are allowed in any phase.

## Test plan
- Defaults: WIDTH = 8, TAPS = 8'b01000100, SEED = 0.
  - Data "1": lfsr becomes 8'hC4. CRC bits 0,0,1,0,0,0,1,1 → done after 8th CRC bit; crc_ok = 1, frame_len = 1.
  - Data "1,0": lfsr becomes 8'h62. CRC bits 0,1,0,0,0,1,1,0 → crc_ok = 1, frame_len = 2. Then flip CRC bit 3 on a second, back-to-back frame → crc_err = 1.
  - Data 4 × "0" with 3-cycle gaps between bits, CRC all-zero → crc_ok = 1, frame_len = 4, busy high throughout.
  - Data "1", CRC 0,0,1, then data_en → done next cycle with trunc_err = 1, crc_err = 1, frame_len = 1. A following valid frame passes.
- Mixed-condition cases:
  - data_en and crc_en both high mid-DATA → proto_err = 1, crc_err = 1; state IDLE and lfsr = SEED afterwards.
  - rst pulsed low after 5 data bits → no done pulse; all outputs 0. A subsequent "1" + 8'hC4 frame gives crc_ok = 1.
  - 8 zero-length frames with SEED = 8'hA5 and crc_en only (bits 1,0,1,0,0,1,0,1) → crc_ok = 1, frame_len = 0.
